binary_adder_seq: RTL and testbench
===================================

BINARY_ADDER_SEQ -- requirements
Module: binary_adder_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and sum width in bits, legal range 2..64.
REQ-002 The block SHALL have parameter CHUNK, default 2, bits added per clock, legal range 1..WIDTH; WIDTH % CHUNK == 0 is a SHALL, checked at elaboration with a fatal error otherwise.
REQ-003 The block SHALL use K = WIDTH/CHUNK, the number of add cycles per operation.
REQ-004 The block SHALL have port clk_i, input, 1 bit, sole clock, rising edge.
REQ-005 The block SHALL have port rstn_i, input, 1 bit, reset; one clock, reset asynchronous and active-low.
REQ-006 The block SHALL have port start_i, input, 1 bit, request to begin an addition.
REQ-007 The block SHALL have ports a_i and b_i, input, WIDTH bits each, operands.
REQ-008 The block SHALL have port cin_i, input, 1 bit, carry-in.
REQ-009 The block SHALL have port busy_o, output, 1 bit, high while an addition is in progress.
REQ-010 The block SHALL have port done_o, output, 1 bit, one-cycle completion pulse.
REQ-011 The block SHALL have port s_o, output, WIDTH bits, sum.
REQ-012 The block SHALL have port cout_o, output, 1 bit, unsigned carry-out.
REQ-013 The block SHALL have port ovf_o, output, 1 bit, two's-complement signed overflow.

Function
REQ-014 The FSM SHALL have states IDLE, ADD and DONE; all outputs SHALL be registered.
REQ-015 In IDLE, start_i=1 at a rising edge SHALL latch a_i, b_i and cin_i, clear the chunk index, and move to ADD; a_i, b_i and cin_i SHALL be don't-care after that edge.
REQ-016 In ADD, each edge SHALL add operand bits [i*CHUNK +: CHUNK] plus the running carry into an internal partial-sum register, then increment i.
REQ-017 The edge that adds chunk K-1 SHALL load s_o, cout_o and ovf_o, set done_o=1, and move to DONE.
REQ-018 With start sampled at edge 0, done_o SHALL be high exactly between edges K and K+1 (latency K cycles); CHUNK=WIDTH gives latency 1.
REQ-019 DONE SHALL move to IDLE unconditionally at the next edge, with done_o returning to 0.
REQ-020 busy_o SHALL be 1 in ADD and DONE, and 0 in IDLE.
REQ-021 start_i SHALL be ignored in ADD and DONE; there is no queueing, and a start during DONE is lost.
REQ-022 s_o, cout_o and ovf_o SHALL change only at completion and hold their value until the next completion; partial sums SHALL never appear on s_o.
REQ-023 Arithmetic SHALL be {cout_o, s_o} = a + b + cin, computed modulo 2^(WIDTH+1) and exact.
REQ-024 ovf_o SHALL equal (a[MSB]==b[MSB]) && (s_o[MSB]!=a[MSB]), using the latched operands.
REQ-025 Back-to-back operation: start_i held high SHALL begin a new operation on the first IDLE edge, i.e. one idle cycle between done pulses, giving a period of K+2 cycles.

Reset
REQ-026 When rstn_i=0, the block SHALL immediately, without waiting for a clock, force state=IDLE, busy_o=0, done_o=0, s_o=0, cout_o=0, ovf_o=0, and clear the chunk index and internal registers.
REQ-027 Reset asserted mid-ADD SHALL abort the operation with no done_o pulse; s_o SHALL read 0, not the previous result.
REQ-028 After rstn_i deasserts, the first edge with start_i=1 SHALL be accepted normally.

Verification (WIDTH=8, CHUNK=2, K=4)
REQ-029 The bench SHALL check: 0x00 + 0x00, cin=0 -> s_o=0x00, cout_o=0, ovf_o=0, with done_o high exactly 4 cycles after the start edge.
REQ-030 The bench SHALL check: 0xFF + 0x01, cin=0 -> s_o=0x00, cout_o=1, ovf_o=0; and 0xA5 + 0x5A, cin=1 -> s_o=0x00, cout_o=1, ovf_o=0.
REQ-031 The bench SHALL check: 0x7F + 0x01, cin=0 -> s_o=0x80, cout_o=0, ovf_o=1; and 0x80 + 0x80, cin=0 -> s_o=0x00, cout_o=1, ovf_o=1.
REQ-032 The bench SHALL check: start a 0x12 + 0x34 operation, then pulse start_i with 0xFF + 0xFF at cycles 2 and 4 -> a single done_o with s_o=0x46, and the second request ignored.
REQ-033 The bench SHALL check: start_i held high with fixed operands 0x01 + 0x02 -> done_o pulses every 6 cycles, and s_o=0x03 is stable throughout.
REQ-034 The bench SHALL check: rstn_i=0 asynchronously at cycle 2 of ADD -> all outputs are 0 before the next edge, no done_o pulse follows, and a fresh 0x10 + 0x20 after release gives s_o=0x30.
REQ-035 The bench SHALL repeat REQ-030 and REQ-031 with CHUNK=1 (latency 8) and CHUNK=8 (latency 1) to confirm the results are identical.

Source files
------------

// File: rtl/binary_adder_seq.sv
// Multi-cycle adder: adds CHUNK bits per clock over K = WIDTH/CHUNK cycles and
// reports sum, unsigned carry-out and signed overflow with a one-cycle done pulse.
module binary_adder_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int K      = WIDTH / CHUNK;
    localparam int K_LAST = K - 32'sd1;
    localparam int IDX_W  = (K > 32'sd1) ? $clog2(K) : 32'sd1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K_LAST);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'sd1);

    if ((WIDTH < 32'sd2) || (WIDTH > 32'sd64) || (CHUNK < 32'sd1) || (CHUNK > WIDTH) ||
        ((WIDTH % CHUNK) != 32'sd0)) begin : g_bad_params
        $fatal(1, "binary_adder_seq: illegal WIDTH/CHUNK combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [CHUNK:0]       chunk_sum_s;
    logic [WIDTH+CHUNK-1:0] psum_shift_s;
    logic                 unused_s;

    // The low chunk of the shifted-out partial sum is the stale slot being discarded.
    assign unused_s = ^psum_shift_s[CHUNK-1:0];

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        psum_d  = psum_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        // Operands shift right each cycle, so the active chunk is always the low bits;
        // the partial sum fills from the top and is complete after K shifts.
        chunk_sum_s  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        psum_shift_s = {chunk_sum_s[CHUNK-1:0], psum_q};

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    a_msb_d = a_i[WIDTH-1];
                    b_msb_d = b_i[WIDTH-1];
                    idx_d   = {IDX_W{1'b0}};
                    psum_d  = {WIDTH{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ADD;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ADD: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_sum_s[CHUNK];
                psum_d  = psum_shift_s[WIDTH+CHUNK-1:CHUNK];
                busy_d  = 1'b1;
                if (idx_q == IDX_LAST) begin
                    s_d     = psum_shift_s[WIDTH+CHUNK-1:CHUNK];
                    cout_d  = chunk_sum_s[CHUNK];
                    ovf_d   = (a_msb_q == b_msb_q) && (psum_shift_s[WIDTH+CHUNK-1] != a_msb_q);
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            idx_q   <= {IDX_W{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            psum_q  <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            psum_q  <= psum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign s_o    = s_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_binary_adder_seq.sv
// Scoreboard bench for binary_adder_seq: three instances (CHUNK=2, 1, 8), directed
// vectors with hand-computed results, a monitor that pops expectations on done_o.
module tb_binary_adder_seq;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start_r [3];
    logic [7:0] a_r     [3];
    logic [7:0] b_r     [3];
    logic       cin_r   [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic [7:0] s_w     [3];
    logic       cout_w  [3];
    logic       ovf_w   [3];

    binary_adder_seq #(.WIDTH(8), .CHUNK(2)) dut_c2 (
        .clk_i(clk), .rstn_i(rstn), .start_i(start_r[0]), .a_i(a_r[0]), .b_i(b_r[0]),
        .cin_i(cin_r[0]), .busy_o(busy_w[0]), .done_o(done_w[0]), .s_o(s_w[0]),
        .cout_o(cout_w[0]), .ovf_o(ovf_w[0]));

    binary_adder_seq #(.WIDTH(8), .CHUNK(1)) dut_c1 (
        .clk_i(clk), .rstn_i(rstn), .start_i(start_r[1]), .a_i(a_r[1]), .b_i(b_r[1]),
        .cin_i(cin_r[1]), .busy_o(busy_w[1]), .done_o(done_w[1]), .s_o(s_w[1]),
        .cout_o(cout_w[1]), .ovf_o(ovf_w[1]));

    binary_adder_seq #(.WIDTH(8), .CHUNK(8)) dut_c8 (
        .clk_i(clk), .rstn_i(rstn), .start_i(start_r[2]), .a_i(a_r[2]), .b_i(b_r[2]),
        .cin_i(cin_r[2]), .busy_o(busy_w[2]), .done_o(done_w[2]), .s_o(s_w[2]),
        .cout_o(cout_w[2]), .ovf_o(ovf_w[2]));

    typedef struct {
        int         d;
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         at;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    exp_t sb[$];
    vec_t vt[4];

    function automatic int k_of(input int d);
        case (d)
            0:       return 4;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, act, want);
        end
    endtask

    task automatic push(input int d, input logic [7:0] s, input logic co, input logic ov, input int at);
        exp_t e;
        e.d = d; e.s = s; e.co = co; e.ov = ov; e.at = at;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (done_w[d] === 1'b1) begin
                if (sb.size() == 0 || sb[0].d != d) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done dut%0d cycle %0d: got done=1 expected none", d, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("sum", d, 32'(s_w[d]), 32'(e.s));
                    chk("cout", d, 32'(cout_w[d]), 32'(e.co));
                    chk("ovf", d, 32'(ovf_w[d]), 32'(e.ov));
                    chk("done_cycle", d, 32'(cyc), 32'(e.at));
                    chk("busy_at_done", d, 32'(busy_w[d]), 32'd1);
                end
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input int d, input vec_t v);
        @(negedge clk);
        a_r[d] = v.a; b_r[d] = v.b; cin_r[d] = v.c; start_r[d] = 1'b1;
        push(d, v.s, v.co, v.ov, cyc + 1 + k_of(d));
        @(negedge clk);
        start_r[d] = 1'b0;
        a_r[d] = 8'($urandom); b_r[d] = 8'($urandom); cin_r[d] = 1'($urandom);
        wait_drain();
    endtask

    initial begin
        int   c;
        vec_t v;
        for (int d = 0; d < 3; d++) begin
            start_r[d] = 1'b0; a_r[d] = 8'h00; b_r[d] = 8'h00; cin_r[d] = 1'b0;
        end
        vt[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        rstn = 1'b1;
        #3 rstn = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_s", d, 32'(s_w[d]), 32'd0);
            chk("rst_cout", d, 32'(cout_w[d]), 32'd0);
            chk("rst_ovf", d, 32'(ovf_w[d]), 32'd0);
            chk("rst_done", d, 32'(done_w[d]), 32'd0);
            chk("rst_busy", d, 32'(busy_w[d]), 32'd0);
        end
        rstn = 1'b1;

        run_op(0, '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) run_op(0, vt[i]);

        // Starts at the 2nd and 4th edge after acceptance must be dropped.
        @(negedge clk);
        c = cyc;
        a_r[0] = 8'h12; b_r[0] = 8'h34; cin_r[0] = 1'b0; start_r[0] = 1'b1;
        push(0, 8'h46, 1'b0, 1'b0, c + 1 + 4);
        @(negedge clk); start_r[0] = 1'b0; a_r[0] = 8'hFF; b_r[0] = 8'hFF;
        @(negedge clk); start_r[0] = 1'b1;
        @(negedge clk); start_r[0] = 1'b0;
        @(negedge clk); start_r[0] = 1'b1;
        @(negedge clk); start_r[0] = 1'b0;
        wait_drain();
        repeat (8) @(negedge clk);
        chk("ignored_start_s", 0, 32'(s_w[0]), 32'h46);
        chk("ignored_start_busy", 0, 32'(busy_w[0]), 32'd0);

        // start_i held high: a done every K+2 = 6 cycles, result stable.
        @(negedge clk);
        c = cyc;
        a_r[0] = 8'h01; b_r[0] = 8'h02; cin_r[0] = 1'b0; start_r[0] = 1'b1;
        push(0, 8'h03, 1'b0, 1'b0, c + 5);
        push(0, 8'h03, 1'b0, 1'b0, c + 11);
        push(0, 8'h03, 1'b0, 1'b0, c + 17);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i >= 4) chk("held_start_s", 0, 32'(s_w[0]), 32'h03);
        end
        start_r[0] = 1'b0;
        wait_drain();

        // Asynchronous reset in the middle of an addition.
        repeat (2) @(negedge clk);
        a_r[0] = 8'h55; b_r[0] = 8'h11; cin_r[0] = 1'b0; start_r[0] = 1'b1;
        @(negedge clk); start_r[0] = 1'b0;
        @(negedge clk);
        chk("busy_mid_add", 0, 32'(busy_w[0]), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_s", 0, 32'(s_w[0]), 32'd0);
        chk("async_rst_cout", 0, 32'(cout_w[0]), 32'd0);
        chk("async_rst_ovf", 0, 32'(ovf_w[0]), 32'd0);
        chk("async_rst_done", 0, 32'(done_w[0]), 32'd0);
        chk("async_rst_busy", 0, 32'(busy_w[0]), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_abort_s", 0, 32'(s_w[0]), 32'd0);
        run_op(0, '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0});

        for (int d = 1; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                v = vt[i];
                run_op(d, v);
            end
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
